load_addr_queue: RTL and testbench
==================================

Name: load_addr_queue

Overview:
- Parametrised successor of the single-entry load address stage.
- Sits between the execute load FU and the load-data stage. Buffers up to DEPTH load micro-ops and computes effective address, byte mask and misalignment at enqueue.
- Applies branch resolve/mispredict to every buffered entry and presents entries in FIFO order over a valid/ready handshake.
- Adds behaviour the single-entry stage lacks: squash-holes that drain automatically, full-flush, misalignment flag, and push-while-full when a pop occurs in the same cycle.

Parameters:
- DEPTH, 4, entry count; power of two, 2..16
- XLEN, 32, address/operand width
- BM_W, 8, branch mask width
- PRF_W, 6, physical dest register index width
- SQ_W, 3, store queue tail index width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a load
- in_ready  out  1  queue accepts this cycle
- in_base  in  XLEN  rs1 value
- in_offset  in  XLEN  sign-extended immediate
- in_dest  in  PRF_W  destination physical register
- in_bm  in  BM_W  branch mask
- in_sq_tail  in  SQ_W  store queue tail snapshot
- in_func  in  3  load func; [1:0] = size (00 B, 01 H, 10 W, 11 invalid), [2] = unsigned
- out_valid  out  1  head entry valid for load-data stage
- out_ready  in  1  load-data stage and load buffer both free
- out_addr  out  XLEN  effective address
- out_byte_mask  out  4  byte mask shifted by addr[1:0]
- out_misaligned  out  1  access crosses word or is size 11
- out_dest, out_bm, out_sq_tail, out_func  out  PRF_W/BM_W/SQ_W/3  head entry fields
- b_mm_resolve  in  BM_W  one-hot resolving branch, 0 when none
- b_mm_mispred  in  1  resolving branch mispredicted
- flush  in  1  full pipeline flush
- count  out  $clog2(DEPTH)+1  occupied slots, including squashed holes

Behaviour:
- Reset (async): head = tail = count = 0; all entry valid bits 0. Outputs: out_valid 0, in_ready 1, all data outputs 0.
- Storage: circular buffer; head/tail pointers wrap at DEPTH.
- Enqueue:
  - Push occurs when in_valid & in_ready at a clock edge.
  - Stored addr = in_base + in_offset, modulo 2^XLEN.
  - Base mask: B = 0001, H = 0011, W = 1111, 11 = 0000. Shift it left by addr[1:0], truncated to 4 bits.
  - misaligned = (H & addr[0]) | (W & addr[1:0] != 0) | (size == 11).
  - Earliest out_valid for a pushed entry is the cycle after the push (1-cycle latency). There is no bypass.
- Pop:
  - pop = (out_valid & out_ready) | head_hole.
  - head_hole = count != 0 & head entry invalid. A hole is dequeued automatically, one per cycle, with out_valid low.
- in_ready = (count < DEPTH) | pop. This is a combinational path from out_ready, which is permitted.
- Branch resolve (b_mm_resolve != 0), applied combinationally and at the edge:
  - Every valid entry with bm & b_mm_resolve has that bit cleared.
  - If b_mm_mispred is also high, that entry's valid bit is cleared instead.
  - The incoming packet is filtered identically before it is written. A mispredicted incoming packet is still accepted as a hole if pushed; this keeps in_ready independent of bm.
  - out_bm shows the cleared mask in the same cycle.
  - out_valid drops in the same cycle if the head entry is squashed, so no handshake occurs on a squashed head.
- flush: synchronous. At the next edge head = tail = count = 0 and all valid bits are cleared. Any push that cycle is dropped. flush has priority over push, pop and resolve.
- Simultaneous push and pop: count is unchanged, and both pointers advance, including when count = DEPTH.
- Empty queue: out_valid = 0, and data outputs hold the stale head slot (don't-care).
- count increments on push and decrements on pop; holes count toward occupancy until drained.

Test Plan:
- Reset mid-stream with 3 entries queued, assert reset asynchronously -> count = 0 and out_valid = 0 immediately, before the next edge; in_ready = 1.
- Push W load, base 0x1000, offset 0x4, dest 5, then out_ready = 1 -> next cycle out_addr 0x1004, mask 1111, misaligned 0, dest 5; count returns to 0 one cycle later.
- Push H load at address 0x2003 -> out_byte_mask 1000, out_misaligned 1. Push B load at 0x2002 -> mask 0100, misaligned 0.
- Fill 4 entries with out_ready = 0 -> in_ready = 0. Then out_ready = 1 with in_valid = 1 -> push and pop in the same cycle, count stays 4, FIFO order preserved across the pointer wrap.
- Entries with bm 0001, 0010, 0001 queued; b_mm_resolve = 0001 with mispred = 1 -> entries 0 and 2 become holes. Head hole drains with no out_valid, entry 1 pops next, entry 2 drains; count goes 3 -> 0.
- Same entries, resolve = 0010 with mispred = 0 -> all entries stay valid, entry 1 out_bm = 0000. flush asserted with in_valid = 1 -> count = 0 next cycle and the incoming packet is not stored.

Source files
------------

// File: rtl/load_addr_queue_if.sv
// load_addr_queue_if: enqueue, dequeue, branch-resolve and flush signals of the load address queue
interface load_addr_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int BM_W  = 8,
   parameter int PRF_W = 6,
   parameter int SQ_W  = 3
);
   logic                       in_valid;
   logic                       in_ready;
   logic [XLEN-1:0]            in_base;
   logic [XLEN-1:0]            in_offset;
   logic [PRF_W-1:0]           in_dest;
   logic [BM_W-1:0]            in_bm;
   logic [SQ_W-1:0]            in_sq_tail;
   logic [2:0]                 in_func;
   logic                       out_valid;
   logic                       out_ready;
   logic [XLEN-1:0]            out_addr;
   logic [3:0]                 out_byte_mask;
   logic                       out_misaligned;
   logic [PRF_W-1:0]           out_dest;
   logic [BM_W-1:0]            out_bm;
   logic [SQ_W-1:0]            out_sq_tail;
   logic [2:0]                 out_func;
   logic [BM_W-1:0]            b_mm_resolve;
   logic                       b_mm_mispred;
   logic                       flush;
   logic [$clog2(DEPTH):0]     count;

   modport master (
      output in_valid, in_base, in_offset, in_dest, in_bm, in_sq_tail, in_func,
      output out_ready, b_mm_resolve, b_mm_mispred, flush,
      input  in_ready, out_valid, out_addr, out_byte_mask, out_misaligned,
      input  out_dest, out_bm, out_sq_tail, out_func, count
   );

   modport slave (
      input  in_valid, in_base, in_offset, in_dest, in_bm, in_sq_tail, in_func,
      input  out_ready, b_mm_resolve, b_mm_mispred, flush,
      output in_ready, out_valid, out_addr, out_byte_mask, out_misaligned,
      output out_dest, out_bm, out_sq_tail, out_func, count
   );
endinterface

// File: rtl/load_addr_queue.sv
// load_addr_queue: DEPTH-entry FIFO of load micro-ops with address generation, branch squash and hole draining
module load_addr_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int BM_W  = 8,
   parameter int PRF_W = 6,
   parameter int SQ_W  = 3
) (
   input logic             clock,
   input logic             reset,
   load_addr_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] mis_q;
   logic [XLEN-1:0]  addr_q [DEPTH];
   logic [3:0]       mask_q [DEPTH];
   logic [PRF_W-1:0] dest_q [DEPTH];
   logic [BM_W-1:0]  bm_q   [DEPTH];
   logic [SQ_W-1:0]  sq_q   [DEPTH];
   logic [2:0]       func_q [DEPTH];
   logic [PW-1:0]    head, tail;
   logic [CW-1:0]    cnt;
   logic [XLEN-1:0]  ea;
   logic [3:0]       base_mask, ea_mask;
   logic             ea_mis, in_squash, head_vld, head_hole, push, pop;

   // effective address, byte mask and misalignment of the incoming load
   always_comb begin
      ea        = bus.in_base + bus.in_offset;
      base_mask = bus.in_func[1:0] == 2'b00 ? 4'b0001 :
                  bus.in_func[1:0] == 2'b01 ? 4'b0011 :
                  bus.in_func[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
      ea_mask   = base_mask << ea[1:0];
      ea_mis    = (bus.in_func[1:0] == 2'b01 & ea[0]) |
                  (bus.in_func[1:0] == 2'b10 & |ea[1:0]) |
                  (bus.in_func[1:0] == 2'b11);
   end

   // head view filtered by a same-cycle resolve; holes pop without a handshake
   always_comb begin
      in_squash     = bus.b_mm_mispred & |(bus.in_bm & bus.b_mm_resolve);
      head_vld      = vld[head] & ~(bus.b_mm_mispred & |(bm_q[head] & bus.b_mm_resolve));
      bus.out_valid = (cnt != '0) & head_vld;
      head_hole     = (cnt != '0) & ~head_vld;
      pop           = (bus.out_valid & bus.out_ready) | head_hole;
      bus.in_ready  = (cnt != CW'(DEPTH)) | pop;
      push          = bus.in_valid & bus.in_ready & ~bus.flush;
   end

   assign bus.out_addr       = addr_q[head];
   assign bus.out_byte_mask  = mask_q[head];
   assign bus.out_misaligned = mis_q[head];
   assign bus.out_dest       = dest_q[head];
   assign bus.out_bm         = bm_q[head] & ~bus.b_mm_resolve;
   assign bus.out_sq_tail    = sq_q[head];
   assign bus.out_func       = func_q[head];
   assign bus.count          = cnt;

   // entry storage, branch-mask update and pointer/occupancy bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         vld   <= '0;
         mis_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            mask_q[i] <= '0;
            dest_q[i] <= '0;
            bm_q[i]   <= '0;
            sq_q[i]   <= '0;
            func_q[i] <= '0;
         end
      end else if (bus.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         vld  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            vld[i]  <= vld[i] & ~(bus.b_mm_mispred & |(bm_q[i] & bus.b_mm_resolve));
            bm_q[i] <= bm_q[i] & ~bus.b_mm_resolve;
         end
         if (push) begin
            vld[tail]    <= ~in_squash;
            addr_q[tail] <= ea;
            mask_q[tail] <= ea_mask;
            mis_q[tail]  <= ea_mis;
            dest_q[tail] <= bus.in_dest;
            bm_q[tail]   <= bus.in_bm & ~bus.b_mm_resolve;
            sq_q[tail]   <= bus.in_sq_tail;
            func_q[tail] <= bus.in_func;
            tail         <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_load_addr_queue.sv
// tb_load_addr_queue: directed scenarios plus randomized run against a queue-based reference model
module tb_load_addr_queue;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [3:0]  m;
      logic        mis;
      logic [5:0]  d;
      logic [7:0]  bm;
      logic [2:0]  sq;
      logic [2:0]  f;
   } ent_t;

   ent_t q[$];

   load_addr_queue_if #(.DEPTH(4), .XLEN(32), .BM_W(8), .PRF_W(6), .SQ_W(3)) bus ();

   load_addr_queue #(.DEPTH(4), .XLEN(32), .BM_W(8), .PRF_W(6), .SQ_W(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_base = 0; bus.in_offset = 0; bus.in_dest = 0;
      bus.in_bm = 0; bus.in_sq_tail = 0; bus.in_func = 0; bus.out_ready = 0;
      bus.b_mm_resolve = 0; bus.b_mm_mispred = 0; bus.flush = 0;
   endtask

   task automatic drive(input logic v, input logic [31:0] base, input logic [31:0] off,
                        input logic [5:0] d, input logic [7:0] bm, input logic [2:0] sq, input logic [2:0] f);
      bus.in_valid = v; bus.in_base = base; bus.in_offset = off; bus.in_dest = d;
      bus.in_bm = bm; bus.in_sq_tail = sq; bus.in_func = f;
   endtask

   task automatic test_reset();
      idle();
      #2;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL rst_out_addr got %h exp 0", bus.out_addr); end
      checks++; if (bus.out_byte_mask !== 4'h0) begin errors++; $display("FAIL rst_mask got %b exp 0000", bus.out_byte_mask); end
      @(negedge clock);
      reset = 0;
      cyc();
   endtask

   task automatic test_word();
      idle();
      drive(1, 32'h1000, 32'h4, 6'd5, 8'h0, 3'd2, 3'b010);
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL word_no_bypass got %b exp 0", bus.out_valid); end
      cyc();
      bus.in_valid = 0;
      bus.out_ready = 1;
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL word_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_addr !== 32'h1004) begin errors++; $display("FAIL word_addr got %h exp 00001004", bus.out_addr); end
      checks++; if (bus.out_byte_mask !== 4'b1111) begin errors++; $display("FAIL word_mask got %b exp 1111", bus.out_byte_mask); end
      checks++; if (bus.out_misaligned !== 1'b0) begin errors++; $display("FAIL word_mis got %b exp 0", bus.out_misaligned); end
      checks++; if (bus.out_dest !== 6'd5) begin errors++; $display("FAIL word_dest got %0d exp 5", bus.out_dest); end
      checks++; if (bus.out_sq_tail !== 3'd2) begin errors++; $display("FAIL word_sq got %0d exp 2", bus.out_sq_tail); end
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL word_count1 got %0d exp 1", bus.count); end
      cyc();
      @(negedge clock);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL word_count0 got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL word_empty got %b exp 0", bus.out_valid); end
      idle();
   endtask

   task automatic test_half_byte();
      idle();
      drive(1, 32'h2000, 32'h3, 6'd7, 8'h0, 3'd0, 3'b001);
      cyc();
      drive(1, 32'h2004, 32'hFFFF_FFFE, 6'd8, 8'h0, 3'd0, 3'b100);
      cyc();
      bus.in_valid = 0;
      bus.out_ready = 1;
      @(negedge clock);
      checks++; if (bus.out_addr !== 32'h2003) begin errors++; $display("FAIL half_addr got %h exp 00002003", bus.out_addr); end
      checks++; if (bus.out_byte_mask !== 4'b1000) begin errors++; $display("FAIL half_mask got %b exp 1000", bus.out_byte_mask); end
      checks++; if (bus.out_misaligned !== 1'b1) begin errors++; $display("FAIL half_mis got %b exp 1", bus.out_misaligned); end
      cyc();
      @(negedge clock);
      checks++; if (bus.out_addr !== 32'h2002) begin errors++; $display("FAIL byte_addr got %h exp 00002002", bus.out_addr); end
      checks++; if (bus.out_byte_mask !== 4'b0100) begin errors++; $display("FAIL byte_mask got %b exp 0100", bus.out_byte_mask); end
      checks++; if (bus.out_misaligned !== 1'b0) begin errors++; $display("FAIL byte_mis got %b exp 0", bus.out_misaligned); end
      checks++; if (bus.out_func !== 3'b100) begin errors++; $display("FAIL byte_func got %b exp 100", bus.out_func); end
      cyc();
      idle();
   endtask

   task automatic test_fill_wrap();
      idle();
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h3000, 32'(i * 4), 6'(10 + i), 8'h0, 3'd0, 3'b010);
         cyc();
      end
      drive(1, 32'h3000, 32'h10, 6'd14, 8'h0, 3'd0, 3'b010);
      @(negedge clock);
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
      cyc();
      bus.out_ready = 1;
      @(negedge clock);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_dest !== 6'd10) begin errors++; $display("FAIL full_head got %0d exp 10", bus.out_dest); end
      cyc();
      drive(1, 32'h3000, 32'h14, 6'd15, 8'h0, 3'd0, 3'b010);
      @(negedge clock);
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL pushpop_count got %0d exp 4", bus.count); end
      checks++; if (bus.out_dest !== 6'd11) begin errors++; $display("FAIL pushpop_head got %0d exp 11", bus.out_dest); end
      cyc();
      bus.in_valid = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checks++; if (bus.out_dest !== 6'(12 + k) || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_order got %0d/%b exp %0d/1", bus.out_dest, bus.out_valid, 12 + k);
         end
         cyc();
      end
      @(negedge clock);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", bus.count); end
      idle();
   endtask

   task automatic test_mispred();
      idle();
      drive(1, 32'h4000, 32'h0, 6'd20, 8'h01, 3'd1, 3'b010); cyc();
      drive(1, 32'h4000, 32'h4, 6'd21, 8'h02, 3'd1, 3'b010); cyc();
      drive(1, 32'h4000, 32'h8, 6'd22, 8'h01, 3'd1, 3'b010); cyc();
      bus.in_valid = 0;
      bus.b_mm_resolve = 8'h01;
      bus.b_mm_mispred = 1;
      bus.out_ready = 1;
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mp_head_squash got %b exp 0", bus.out_valid); end
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mp_count3 got %0d exp 3", bus.count); end
      cyc();
      bus.b_mm_resolve = 0;
      bus.b_mm_mispred = 0;
      @(negedge clock);
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL mp_count2 got %0d exp 2", bus.count); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_dest !== 6'd21) begin
         errors++; $display("FAIL mp_survivor got %b/%0d exp 1/21", bus.out_valid, bus.out_dest);
      end
      cyc();
      @(negedge clock);
      checks++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mp_tail_hole got %0d/%b exp 1/0", bus.count, bus.out_valid);
      end
      cyc();
      @(negedge clock);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mp_drained got %0d exp 0", bus.count); end
      idle();
   endtask

   task automatic test_resolve_flush();
      idle();
      drive(1, 32'h5000, 32'h0, 6'd30, 8'h01, 3'd3, 3'b010); cyc();
      drive(1, 32'h5000, 32'h4, 6'd31, 8'h02, 3'd3, 3'b010); cyc();
      drive(1, 32'h5000, 32'h8, 6'd32, 8'h01, 3'd3, 3'b010); cyc();
      bus.in_valid = 0;
      bus.b_mm_resolve = 8'h02;
      @(negedge clock);
      checks++; if (bus.out_valid !== 1'b1 || bus.count !== 3'd3) begin
         errors++; $display("FAIL rs_valid got %b/%0d exp 1/3", bus.out_valid, bus.count);
      end
      checks++; if (bus.out_bm !== 8'h01) begin errors++; $display("FAIL rs_head_bm got %h exp 01", bus.out_bm); end
      cyc();
      bus.b_mm_resolve = 0;
      bus.out_ready = 1;
      @(negedge clock);
      checks++; if (bus.out_dest !== 6'd30) begin errors++; $display("FAIL rs_pop0 got %0d exp 30", bus.out_dest); end
      cyc();
      @(negedge clock);
      checks++; if (bus.out_dest !== 6'd31 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL rs_pop1 got %0d/%b exp 31/1", bus.out_dest, bus.out_valid);
      end
      checks++; if (bus.out_bm !== 8'h00) begin errors++; $display("FAIL rs_cleared_bm got %h exp 00", bus.out_bm); end
      cyc();
      bus.out_ready = 0;
      bus.flush = 1;
      drive(1, 32'h5000, 32'hC, 6'd33, 8'h00, 3'd3, 3'b010);
      cyc();
      idle();
      @(negedge clock);
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_clear got %0d/%b exp 0/0", bus.count, bus.out_valid);
      end
      cyc();
      @(negedge clock);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_drop got %0d exp 0", bus.count); end
   endtask

   task automatic test_async_reset();
      idle();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h6000, 32'(i), 6'(40 + i), 8'h0, 3'd0, 3'b000);
         cyc();
      end
      bus.in_valid = 0;
      #2;
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL ar_pre got %0d exp 3", bus.count); end
      reset = 1;
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got %b exp 1", bus.in_ready); end
      #2;
      reset = 0;
      cyc();
   endtask

   task automatic test_random();
      q.delete();
      for (int c = 0; c < 600; c++) begin
         int   n, nb, mm;
         logic hv, e_ov, e_pop, e_ir;
         ent_t e;
         bus.in_valid     = $urandom_range(0, 9) < 7;
         bus.in_base      = $urandom;
         bus.in_offset    = $urandom;
         bus.in_dest      = 6'($urandom);
         bus.in_bm        = 8'(1 << $urandom_range(0, 3));
         bus.in_sq_tail   = 3'($urandom);
         bus.in_func      = 3'($urandom);
         bus.b_mm_resolve = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 3)) : 8'h0;
         bus.b_mm_mispred = 1'($urandom_range(0, 1));
         bus.flush        = $urandom_range(0, 29) == 0;
         bus.out_ready    = $urandom_range(0, 9) < 6;
         @(negedge clock);
         n     = q.size();
         hv    = n > 0 && q[0].v && !(bus.b_mm_mispred && (q[0].bm & bus.b_mm_resolve) != 0);
         e_ov  = hv;
         e_pop = (e_ov && bus.out_ready) || (n > 0 && !hv);
         e_ir  = n < 4 || e_pop;
         checks++; if (bus.count !== 3'(n)) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.count, n); end
         checks++; if (bus.out_valid !== e_ov) begin errors++; $display("FAIL rnd_out_valid c%0d got %b exp %b", c, bus.out_valid, e_ov); end
         checks++; if (bus.in_ready !== e_ir) begin errors++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, bus.in_ready, e_ir); end
         if (e_ov) begin
            checks++;
            if (bus.out_addr !== q[0].a || bus.out_byte_mask !== q[0].m || bus.out_misaligned !== q[0].mis ||
                bus.out_dest !== q[0].d || bus.out_bm !== (q[0].bm & ~bus.b_mm_resolve) ||
                bus.out_sq_tail !== q[0].sq || bus.out_func !== q[0].f) begin
               errors++;
               $display("FAIL rnd_head c%0d got %h/%b/%b/%0d/%h/%0d/%b exp %h/%b/%b/%0d/%h/%0d/%b", c,
                        bus.out_addr, bus.out_byte_mask, bus.out_misaligned, bus.out_dest, bus.out_bm,
                        bus.out_sq_tail, bus.out_func, q[0].a, q[0].m, q[0].mis, q[0].d,
                        q[0].bm & ~bus.b_mm_resolve, q[0].sq, q[0].f);
            end
         end
         if (bus.flush) q.delete();
         else begin
            foreach (q[i])
               if (q[i].v && (q[i].bm & bus.b_mm_resolve) != 0) begin
                  if (bus.b_mm_mispred) q[i].v = 0;
                  else q[i].bm = q[i].bm & ~bus.b_mm_resolve;
               end
            if (e_pop) void'(q.pop_front());
            if (bus.in_valid && e_ir) begin
               e.a   = bus.in_base + bus.in_offset;
               nb    = bus.in_func[1:0] == 2'd0 ? 1 : bus.in_func[1:0] == 2'd1 ? 2 : bus.in_func[1:0] == 2'd2 ? 4 : 0;
               mm    = ((1 << nb) - 1) << (e.a % 4);
               e.m   = mm[3:0];
               e.mis = bus.in_func[1:0] == 2'd3 || (nb > 1 && (e.a % nb) != 0);
               e.d   = bus.in_dest;
               e.sq  = bus.in_sq_tail;
               e.f   = bus.in_func;
               e.v   = !(bus.b_mm_mispred && (bus.in_bm & bus.b_mm_resolve) != 0);
               e.bm  = bus.in_bm & ~bus.b_mm_resolve;
               q.push_back(e);
            end
         end
         cyc();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_word();
      test_half_byte();
      test_fill_wrap();
      test_mispred();
      test_resolve_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
